// File: rtl/flip_flops.sv
`default_nettype none
// ============================================================================
// Module      : flip_flops
// Description : SR, JK, D and T flip-flops sharing one clock enable and data
//               pair, with an SR-invalid pulse and a modulo-16 JK toggle count.
// Revision    : 1.0 - initial release
// ============================================================================
module flip_flops (
   input  logic       clk,
   input  logic       rst,
   input  logic       en,
   input  logic       a,
   input  logic       b,
   output logic       sr_q,
   output logic       sr_qn,
   output logic       jk_q,
   output logic       jk_qn,
   output logic       d_q,
   output logic       d_qn,
   output logic       t_q,
   output logic       t_qn,
   output logic       sr_invalid,
   output logic [3:0] jk_toggles
);

   localparam logic [3:0] c_COUNT_ONE = 4'd1;

   logic       sr_state_q, sr_state_d;
   logic       jk_state_q, jk_state_d;
   logic       d_state_q,  d_state_d;
   logic       t_state_q,  t_state_d;
   logic       sr_inv_q,   sr_inv_d;
   logic [3:0] jk_cnt_q,   jk_cnt_d;

   // a is R/K/D/T and b is S/J; every element samples the same pair.
   logic w_set;
   logic w_clr;
   assign w_set = b;
   assign w_clr = a;

   always_comb begin
      sr_state_d = sr_state_q;
      jk_state_d = jk_state_q;
      d_state_d  = d_state_q;
      t_state_d  = t_state_q;
      sr_inv_d   = 1'b0;
      jk_cnt_d   = jk_cnt_q;
      if (en) begin
         case ({w_set, w_clr})
            2'b10:   sr_state_d = 1'b1;
            2'b01:   sr_state_d = 1'b0;
            2'b11:   sr_inv_d   = 1'b1;
            default: sr_state_d = sr_state_q;
         endcase
         case ({w_set, w_clr})
            2'b10:   jk_state_d = 1'b1;
            2'b01:   jk_state_d = 1'b0;
            2'b11: begin
               jk_state_d = ~jk_state_q;
               jk_cnt_d   = jk_cnt_q + c_COUNT_ONE;
            end
            default: jk_state_d = jk_state_q;
         endcase
         d_state_d = a;
         t_state_d = t_state_q ^ a;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         sr_state_q <= 1'b0;
         jk_state_q <= 1'b0;
         d_state_q  <= 1'b0;
         t_state_q  <= 1'b0;
         sr_inv_q   <= 1'b0;
         jk_cnt_q   <= 4'd0;
      end else begin
         sr_state_q <= sr_state_d;
         jk_state_q <= jk_state_d;
         d_state_q  <= d_state_d;
         t_state_q  <= t_state_d;
         sr_inv_q   <= sr_inv_d;
         jk_cnt_q   <= jk_cnt_d;
      end
   end

   // Complements are derived combinationally so they can never disagree.
   assign sr_q       = sr_state_q;
   assign sr_qn      = ~sr_state_q;
   assign jk_q       = jk_state_q;
   assign jk_qn      = ~jk_state_q;
   assign d_q        = d_state_q;
   assign d_qn       = ~d_state_q;
   assign t_q        = t_state_q;
   assign t_qn       = ~t_state_q;
   assign sr_invalid = sr_inv_q;
   assign jk_toggles = jk_cnt_q;

endmodule
`default_nettype wire

// File: tb/tb_flip_flops.sv
`default_nettype none
// ============================================================================
// Module      : tb_flip_flops
// Description : Directed and random checks of flip_flops against a
//               behavioural model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_flip_flops;

   logic       clk = 1'b0;
   logic       rst = 1'b0;
   logic       en  = 1'b0;
   logic       a   = 1'b0;
   logic       b   = 1'b0;
   logic       sr_q, sr_qn, jk_q, jk_qn, d_q, d_qn, t_q, t_qn, sr_invalid;
   logic [3:0] jk_toggles;

   int n_assert = 0;
   int n_fail   = 0;

   // Behavioural reference state
   bit m_sr, m_jk, m_d, m_t, m_inv;
   int m_cnt;

   flip_flops dut (
      .clk        (clk),
      .rst        (rst),
      .en         (en),
      .a          (a),
      .b          (b),
      .sr_q       (sr_q),
      .sr_qn      (sr_qn),
      .jk_q       (jk_q),
      .jk_qn      (jk_qn),
      .d_q        (d_q),
      .d_qn       (d_qn),
      .t_q        (t_q),
      .t_qn       (t_qn),
      .sr_invalid (sr_invalid),
      .jk_toggles (jk_toggles)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [3:0] obs, input logic [3:0] exp);
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic check_model(input string tag);
      chk({tag, " sr_q"},       {3'b0, sr_q},       {3'b0, m_sr});
      chk({tag, " sr_qn"},      {3'b0, sr_qn},      {3'b0, !m_sr});
      chk({tag, " jk_q"},       {3'b0, jk_q},       {3'b0, m_jk});
      chk({tag, " jk_qn"},      {3'b0, jk_qn},      {3'b0, !m_jk});
      chk({tag, " d_q"},        {3'b0, d_q},        {3'b0, m_d});
      chk({tag, " d_qn"},       {3'b0, d_qn},       {3'b0, !m_d});
      chk({tag, " t_q"},        {3'b0, t_q},        {3'b0, m_t});
      chk({tag, " t_qn"},       {3'b0, t_qn},       {3'b0, !m_t});
      chk({tag, " sr_invalid"}, {3'b0, sr_invalid}, {3'b0, m_inv});
      chk({tag, " jk_toggles"}, jk_toggles,         4'(m_cnt));
   endtask

   // One clock edge: drive, update the model from the rules, check 1 ns later.
   task automatic step(input string tag, input bit r, input bit e, input bit aa, input bit bb);
      rst = r; en = e; a = aa; b = bb;
      @(posedge clk);
      if (r) begin
         m_sr = 0; m_jk = 0; m_d = 0; m_t = 0; m_inv = 0; m_cnt = 0;
      end else if (!e) begin
         m_inv = 0;
      end else begin
         // SR: S=b, R=a
         if (bb && !aa)      m_sr = 1;
         else if (aa && !bb) m_sr = 0;
         m_inv = aa && bb;
         // JK: J=b, K=a
         if (bb && aa) begin
            m_jk  = !m_jk;
            m_cnt = (m_cnt + 1) % 16;
         end else if (bb) m_jk = 1;
         else if (aa)     m_jk = 0;
         m_d = aa;
         if (aa) m_t = !m_t;
      end
      #1;
      check_model(tag);
   endtask

   initial begin
      bit tseq[6];
      bit dseq[4];

      // Reset state
      step("reset", 1, 0, 0, 0);

      // Single enabled edge: SR set, JK set, D=0, T hold
      step("set", 0, 1, 0, 1);
      chk("set sr_q const", {3'b0, sr_q}, 4'd1);
      chk("set jk_q const", {3'b0, jk_q}, 4'd1);

      // 17 JK toggles from reset wraps the counter to 1
      step("reset2", 1, 1, 1, 1);
      for (int i = 0; i < 17; i++) step("toggle17", 0, 1, 1, 1);
      chk("toggle17 jk_toggles const", jk_toggles, 4'd1);
      chk("toggle17 jk_q const", {3'b0, jk_q}, 4'd1);
      chk("toggle17 t_q const", {3'b0, t_q}, 4'd1);
      chk("toggle17 sr_q const", {3'b0, sr_q}, 4'd0);

      // Hold with en=0 after sr_q=1
      step("preset_sr", 0, 1, 0, 1);
      for (int i = 0; i < 3; i++) step("hold_en0", 0, 0, 1, 1);
      chk("hold sr_q const", {3'b0, sr_q}, 4'd1);
      chk("hold sr_invalid const", {3'b0, sr_invalid}, 4'd0);

      // D sequence
      dseq = '{1, 0, 1, 1};
      for (int i = 0; i < 4; i++) begin
         step("dseq", 0, 1, dseq[i], 0);
         chk("dseq d_q const", {3'b0, d_q}, {3'b0, dseq[i]});
      end

      // Reach count=5 with all q=1, then reset with every input high
      step("reset3", 1, 0, 0, 0);
      for (int i = 0; i < 3; i++) step("build", 0, 1, 1, 1);
      step("build_set", 0, 1, 0, 1);
      for (int i = 0; i < 2; i++) step("build", 0, 1, 1, 1);
      chk("build jk_toggles const", jk_toggles, 4'd5);
      chk("build all q const", {sr_q, jk_q, d_q, t_q}, 4'hF);
      step("rst_dominates", 1, 1, 1, 1);
      chk("rst_dominates q const", {sr_q, jk_q, d_q, t_q}, 4'h0);
      chk("rst_dominates cnt const", jk_toggles, 4'd0);

      // Alternating enable with a=1, b=0
      tseq = '{1, 1, 0, 0, 1, 1};
      for (int i = 0; i < 6; i++) begin
         step("alt_en", 0, (i % 2) == 0, 1, 0);
         chk("alt_en t_q const", {3'b0, t_q}, {3'b0, tseq[i]});
      end

      // Random stimulus with occasional reset
      for (int i = 0; i < 400; i++)
         step("random", $urandom_range(15) == 0, $urandom_range(3) != 0,
              1'($urandom), 1'($urandom));

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule
`default_nettype wire
